mpu_store_stream: RTL and testbench
===================================

# mpu_store_stream

Parametrised matrix store engine between the matrix register file and external memory. It streams one matrix element per cycle under a valid/ready handshake, with full backpressure support. It can emit the matrix in row-major or transposed (column-major) order, reports completion and size errors, and replaces the fixed-size, handshake-free store path in the MPU.

## Interface

Parameters:
- DATA_W, 32: element width (float_sp bit width).
- M_MAX, 8: maximum supported rows.
- N_MAX, 8: maximum supported columns.
- REG_BITS, 3: matrix register address width.
- Derived: MW = $clog2(M_MAX+1), NW = $clog2(N_MAX+1), XW = max(MW, NW).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- store_req_in  in  1  start request; sampled only in IDLE.
- transpose_in  in  1  order select, sampled with store_req_in (0 = row-major, 1 = column-major).
- store_addr_in  in  REG_BITS  source matrix register, sampled with store_req_in.
- store_ready_in  in  1  register file grant; sampled only in REQUEST.
- reg_m_size_in  in  MW  source rows; sampled on the grant cycle.
- reg_n_size_in  in  NW  source columns; sampled on the grant cycle.
- reg_element_in  in  DATA_W  element at (reg_i_loc_out, reg_j_loc_out); combinational, same cycle.
- reg_store_req_out  out  1  register file access request.
- reg_store_addr_out  out  REG_BITS  latched register address.
- reg_i_loc_out  out  MW  read row pointer.
- reg_j_loc_out  out  NW  read column pointer.
- mem_valid_out  out  1  beat valid.
- mem_ready_in  in  1  memory accepts the beat.
- mem_element_out  out  DATA_W  beat data.
- mem_i_out  out  XW  destination row of the beat.
- mem_j_out  out  XW  destination column of the beat.
- mem_last_out  out  1  final beat of the matrix.
- mem_m_size_out  out  XW  destination rows (M, or N when transposed).
- mem_n_size_out  out  XW  destination columns (N, or M when transposed).
- busy_out  out  1  state != IDLE.
- done_out  out  1  one-cycle completion pulse.
- err_out  out  1  one-cycle size-error pulse.

## Operation

- States: IDLE, REQUEST, STREAM, DRAIN, ERROR.
- IDLE:
  - When store_req_in = 1, latch transpose_in and store_addr_in, then go to REQUEST.
  - store_req_in is ignored in every other state.
- REQUEST:
  - reg_store_req_out = 1.
  - On store_ready_in = 1, latch M and N.
  - If M = 0, N = 0, M > M_MAX or N > N_MAX, go to ERROR. Otherwise clear the pointers and go to STREAM.
- ERROR: err_out = 1 for one cycle, then IDLE. No memory beats are produced.
- STREAM:
  - reg_store_req_out = 1.
  - Define load = !mem_valid_out || mem_ready_in.
  - On load, capture reg_element_in and the current (i,j) into the output register, set mem_valid_out, and advance the pointers.
  - With no load, pointers and output hold.
- Pointer order:
  - Row-major: j increments; when j = N-1, j resets to 0 and i increments.
  - Transposed: i increments; when i = M-1, i resets to 0 and j increments.
- The load of the final element (i = M-1 and j = N-1) sets mem_last_out and moves to DRAIN.
- DRAIN:
  - reg_store_req_out = 0.
  - The output register holds until mem_ready_in = 1.
  - Then mem_valid_out and mem_last_out drop, state goes to IDLE, and done_out pulses in that next cycle.
- Coordinates:
  - Row-major: mem_i_out = i, mem_j_out = j.
  - Transposed: mem_i_out = j, mem_j_out = i, and the size outputs are swapped.
- Width rule: coordinates are zero-extended to XW.
- mem_element_out, mem_i_out, mem_j_out and mem_last_out are stable while mem_valid_out = 1 and mem_ready_in = 0.

## Timing

- Reset: all outputs are 0 and state is IDLE. Any pending beat is dropped unacknowledged. Reset mid-operation aborts with no done_out and no err_out.
- Cycle numbering:
  - Request at cycle t puts REQUEST at t+1.
  - Grant at cycle g puts STREAM at g+1; the first beat is valid at g+2.
- Throughput is one beat per cycle with mem_ready_in held high. An M×N matrix occupies beats g+2 to g+1+M·N.
- done_out is asserted the cycle after the last handshake. busy_out is already 0 in that same cycle.
- A new store_req_in is accepted in the cycle done_out is high.
- An error pulse occurs at g+1; IDLE is at g+2.
- A 1×1 matrix goes straight from STREAM to DRAIN. The single beat has mem_last_out = 1.

## Test plan

- 2×3 row-major, ready always high: beats (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) at g+2..g+7. Last beat only on (1,2). done_out at g+8. Sizes are 2/3.
- 2×3 transposed: source order (0,0),(1,0),(0,1),(1,1),(0,2),(1,2). mem coordinates (0,0),(0,1),(1,0),(1,1),(2,0),(2,1). Sizes are 3/2.
- Backpressure on 3×3: toggle mem_ready_in with a random pattern. Data is held stable during stalls, there are no duplicates or drops, exactly 9 handshakes occur, and pointers freeze while stalled.
- 1×1 and M_MAX×N_MAX: correct last beat; no pointer overflow at the maximum size.
- Size error with M = 0 and, separately, N = N_MAX+1: err_out pulses at g+1, mem_valid_out never rises, and the next request works normally.
- rst asserted mid-stream with valid high and ready low: all outputs are 0 the next cycle, there is no done_out, and a subsequent 2×2 store completes correctly.

Source files
------------

// File: rtl/mpu_store_stream_if.sv
// mpu_store_stream_if: element stream from the store engine towards external memory.
interface mpu_store_stream_if #(
  parameter int DATA_W = 32,
  parameter int XW     = 4
);
  logic              mem_valid_out;
  logic              mem_ready_in;
  logic [DATA_W-1:0] mem_element_out;
  logic [XW-1:0]     mem_i_out;
  logic [XW-1:0]     mem_j_out;
  logic              mem_last_out;
  logic [XW-1:0]     mem_m_size_out;
  logic [XW-1:0]     mem_n_size_out;
  modport master (
    output mem_valid_out, mem_element_out, mem_i_out, mem_j_out, mem_last_out,
           mem_m_size_out, mem_n_size_out,
    input  mem_ready_in
  );
  modport slave (
    input  mem_valid_out, mem_element_out, mem_i_out, mem_j_out, mem_last_out,
           mem_m_size_out, mem_n_size_out,
    output mem_ready_in
  );
endinterface

// File: rtl/mpu_store_stream.sv
// mpu_store_stream: streams a matrix register out to memory, row-major or transposed, under valid/ready.
module mpu_store_stream #(
  parameter  int DATA_W   = 32,
  parameter  int M_MAX    = 8,
  parameter  int N_MAX    = 8,
  parameter  int REG_BITS = 3,
  localparam int MW       = $clog2(M_MAX + 1),
  localparam int NW       = $clog2(N_MAX + 1),
  localparam int XW       = (MW > NW) ? MW : NW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                store_req_in,
  input  logic                transpose_in,
  input  logic [REG_BITS-1:0] store_addr_in,
  input  logic                store_ready_in,
  input  logic [MW-1:0]       reg_m_size_in,
  input  logic [NW-1:0]       reg_n_size_in,
  input  logic [DATA_W-1:0]   reg_element_in,
  output logic                reg_store_req_out,
  output logic [REG_BITS-1:0] reg_store_addr_out,
  output logic [MW-1:0]       reg_i_loc_out,
  output logic [NW-1:0]       reg_j_loc_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                err_out,
  mpu_store_stream_if.master  mem
);
  typedef enum logic [2:0] {IDLE, REQUEST, STREAM, DRAIN, ERROR} state_t;
  state_t        state;
  logic          tr;
  logic [MW-1:0] m, i;
  logic [NW-1:0] n, j;
  logic          load, row_end, col_end, fin, bad;
  assign load    = !mem.mem_valid_out || mem.mem_ready_in;
  assign row_end = j == n - NW'(1);
  assign col_end = i == m - MW'(1);
  assign fin     = row_end && col_end;
  assign bad     = reg_m_size_in == '0 || reg_n_size_in == '0 ||
                   reg_m_size_in > MW'(M_MAX) || reg_n_size_in > NW'(N_MAX);
  assign reg_store_req_out  = state == REQUEST || state == STREAM;
  assign busy_out           = state != IDLE;
  assign reg_i_loc_out      = i;
  assign reg_j_loc_out      = j;
  assign mem.mem_m_size_out = tr ? XW'(n) : XW'(m);
  assign mem.mem_n_size_out = tr ? XW'(m) : XW'(n);
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      tr                  <= 1'b0;
      m                   <= '0;
      n                   <= '0;
      i                   <= '0;
      j                   <= '0;
      reg_store_addr_out  <= '0;
      done_out            <= 1'b0;
      err_out             <= 1'b0;
      mem.mem_valid_out   <= 1'b0;
      mem.mem_element_out <= '0;
      mem.mem_i_out       <= '0;
      mem.mem_j_out       <= '0;
      mem.mem_last_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      err_out  <= 1'b0;
      case (state)
        IDLE: if (store_req_in) begin
          tr                 <= transpose_in;
          reg_store_addr_out <= store_addr_in;
          state              <= REQUEST;
        end
        REQUEST: if (store_ready_in) begin
          m       <= reg_m_size_in;
          n       <= reg_n_size_in;
          i       <= '0;
          j       <= '0;
          err_out <= bad;
          state   <= bad ? ERROR : STREAM;
        end
        ERROR: state <= IDLE;
        STREAM: if (load) begin
          mem.mem_valid_out   <= 1'b1;
          mem.mem_element_out <= reg_element_in;
          mem.mem_i_out       <= tr ? XW'(j) : XW'(i);
          mem.mem_j_out       <= tr ? XW'(i) : XW'(j);
          mem.mem_last_out    <= fin;
          // pointers return to zero after the final element so they never exceed the matrix
          i     <= fin ? '0 : tr ? (col_end ? '0 : i + MW'(1)) : (row_end ? i + MW'(1) : i);
          j     <= fin ? '0 : tr ? (col_end ? j + NW'(1) : j) : (row_end ? '0 : j + NW'(1));
          state <= fin ? DRAIN : STREAM;
        end
        DRAIN: if (mem.mem_ready_in) begin
          mem.mem_valid_out <= 1'b0;
          mem.mem_last_out  <= 1'b0;
          done_out          <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpu_store_stream.sv
// tb_mpu_store_stream: randomized directed checks of the store engine against a queue-based beat model.
module tb_mpu_store_stream;
  localparam int DATA_W   = 32;
  localparam int M_MAX    = 8;
  localparam int N_MAX    = 8;
  localparam int REG_BITS = 3;
  localparam int MW       = $clog2(M_MAX + 1);
  localparam int NW       = $clog2(N_MAX + 1);
  localparam int XW       = (MW > NW) ? MW : NW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                store_req_in = 1'b0;
  logic                transpose_in = 1'b0;
  logic [REG_BITS-1:0] store_addr_in = '0;
  logic                store_ready_in = 1'b0;
  logic [MW-1:0]       reg_m_size_in = '0;
  logic [NW-1:0]       reg_n_size_in = '0;
  logic [DATA_W-1:0]   reg_element_in;
  logic                reg_store_req_out;
  logic [REG_BITS-1:0] reg_store_addr_out;
  logic [MW-1:0]       reg_i_loc_out;
  logic [NW-1:0]       reg_j_loc_out;
  logic                busy_out, done_out, err_out;
  int                  vectors = 0;
  int                  miscompares = 0;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                i;
    int                j;
    bit                last;
  } beat_t;
  beat_t             q[$];
  logic [DATA_W-1:0] src [16][16];

  mpu_store_stream_if #(.DATA_W(DATA_W), .XW(XW)) mem ();

  mpu_store_stream #(.DATA_W(DATA_W), .M_MAX(M_MAX), .N_MAX(N_MAX), .REG_BITS(REG_BITS)) dut (
    .clk(clk), .rst(rst), .store_req_in(store_req_in), .transpose_in(transpose_in),
    .store_addr_in(store_addr_in), .store_ready_in(store_ready_in),
    .reg_m_size_in(reg_m_size_in), .reg_n_size_in(reg_n_size_in), .reg_element_in(reg_element_in),
    .reg_store_req_out(reg_store_req_out), .reg_store_addr_out(reg_store_addr_out),
    .reg_i_loc_out(reg_i_loc_out), .reg_j_loc_out(reg_j_loc_out),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out), .mem(mem)
  );

  // register file model: combinational read at the engine's pointers
  assign reg_element_in = src[reg_i_loc_out][reg_j_loc_out];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int m, input int n, input bit t, output logic [REG_BITS-1:0] a);
    a = REG_BITS'($urandom);
    store_req_in  = 1'b1;
    transpose_in  = t;
    store_addr_in = a;
    step();
    store_req_in  = 1'b0;
    transpose_in  = 1'($urandom);
    store_addr_in = REG_BITS'($urandom);
    check("req_busy", busy_out, 1);
    check("req_regreq", reg_store_req_out, 1);
    check("done_one_cycle", done_out, 0);
    repeat ($urandom_range(2)) begin
      step();
      check("wait_grant", reg_store_req_out, 1);
    end
    store_ready_in = 1'b1;
    reg_m_size_in  = MW'(m);
    reg_n_size_in  = NW'(n);
    step();
    store_ready_in = 1'b0;
    reg_m_size_in  = MW'($urandom);
    reg_n_size_in  = NW'($urandom);
  endtask

  task automatic run_store(input int m, input int n, input bit t, input int pct);
    logic [REG_BITS-1:0] a;
    logic [MW-1:0]       pi;
    logic [NW-1:0]       pj;
    beat_t               b;
    bit                  stalled, seen, full;
    int                  cyc;
    q.delete();
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) src[r][c] = $urandom;
    if (!t) begin
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++) q.push_back('{src[r][c], r, c, r == m-1 && c == n-1});
    end else begin
      for (int c = 0; c < n; c++)
        for (int r = 0; r < m; r++) q.push_back('{src[r][c], c, r, r == m-1 && c == n-1});
    end
    request(m, n, t, a);
    check("addr_latch", reg_store_addr_out, 64'(a));
    check("m_size", mem.mem_m_size_out, 64'(t ? n : m));
    check("n_size", mem.mem_n_size_out, 64'(t ? m : n));
    check("no_beat_g1", mem.mem_valid_out, 0);
    full = pct >= 100;
    cyc = 1;
    stalled = 0;
    seen = 0;
    while (q.size() > 0 && cyc < 4 * m * n + 50) begin
      if (stalled) begin
        check("ptr_freeze_i", reg_i_loc_out, 64'(pi));
        check("ptr_freeze_j", reg_j_loc_out, 64'(pj));
      end
      if (mem.mem_valid_out) begin
        b = q[0];
        if (!seen && full) check("first_beat_cycle", 64'(cyc), 2);
        seen = 1;
        check("beat_data", mem.mem_element_out, 64'(b.d));
        check("beat_i", mem.mem_i_out, 64'(b.i));
        check("beat_j", mem.mem_j_out, 64'(b.j));
        check("beat_last", mem.mem_last_out, 64'(b.last));
      end
      mem.mem_ready_in = $urandom_range(99) < pct;
      stalled = mem.mem_valid_out && !mem.mem_ready_in;
      pi = reg_i_loc_out;
      pj = reg_j_loc_out;
      if (mem.mem_valid_out && mem.mem_ready_in) void'(q.pop_front());
      step();
      cyc++;
    end
    check("all_beats_taken", 64'(q.size()), 0);
    check("done_pulse", done_out, 1);
    check("done_not_busy", busy_out, 0);
    check("done_valid_low", mem.mem_valid_out, 0);
    check("done_last_low", mem.mem_last_out, 0);
    if (full) check("done_cycle", 64'(cyc), 64'(m * n + 2));
    mem.mem_ready_in = 1'($urandom);
  endtask

  task automatic run_err(input int m, input int n);
    logic [REG_BITS-1:0] a;
    request(m, n, 1'($urandom), a);
    check("err_pulse", err_out, 1);
    check("err_no_beat", mem.mem_valid_out, 0);
    check("err_busy", busy_out, 1);
    step();
    check("err_one_cycle", err_out, 0);
    check("err_idle", busy_out, 0);
    check("err_no_beat2", mem.mem_valid_out, 0);
    check("err_no_done", done_out, 0);
  endtask

  task automatic run_reset_abort();
    logic [REG_BITS-1:0] a;
    int                  k;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) src[r][c] = $urandom;
    mem.mem_ready_in = 1'b0;
    request(3, 3, 1'b0, a);
    k = 0;
    while (!mem.mem_valid_out && k < 10) begin
      step();
      k++;
    end
    check("abort_valid_seen", mem.mem_valid_out, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", mem.mem_valid_out, 0);
    check("abort_elem", mem.mem_element_out, 0);
    check("abort_last", mem.mem_last_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_regreq", reg_store_req_out, 0);
    check("abort_ptr", {reg_i_loc_out, reg_j_loc_out}, 0);
    check("abort_size", {mem.mem_m_size_out, mem.mem_n_size_out}, 0);
    check("abort_done", done_out, 0);
    step();
    check("abort_no_done", done_out, 0);
    check("abort_no_err", err_out, 0);
  endtask

  initial begin
    mem.mem_ready_in = 1'b0;
    repeat (3) step();
    check("rst_valid", mem.mem_valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done_err", {done_out, err_out}, 0);
    check("rst_regreq", reg_store_req_out, 0);
    check("rst_addr", reg_store_addr_out, 0);
    check("rst_ij", {mem.mem_i_out, mem.mem_j_out, mem.mem_last_out}, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy_out, 0);
    run_store(2, 3, 1'b0, 100);
    run_store(2, 3, 1'b1, 100);
    run_store(3, 3, 1'b0, 50);
    run_store(3, 3, 1'b1, 50);
    run_store(1, 1, 1'b0, 100);
    run_store(1, 1, 1'b1, 60);
    run_store(M_MAX, N_MAX, 1'b0, 100);
    run_store(M_MAX, N_MAX, 1'b1, 70);
    run_err(0, 3);
    run_store(2, 2, 1'b0, 100);
    run_err(3, N_MAX + 1);
    run_err(M_MAX + 1, 2);
    run_store(3, 2, 1'b1, 100);
    run_reset_abort();
    run_store(2, 2, 1'b0, 100);
    for (int k = 0; k < 6; k++)
      run_store($urandom_range(M_MAX, 1), $urandom_range(N_MAX, 1), 1'($urandom), $urandom_range(100, 30));
    step();
    check("final_idle", busy_out, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
